// File: rtl/instr_encoder_loader_if.sv
// Field-set input channel and instruction-memory write channel of the encoder/loader.
// in_valid/in_ready: a field set transfers on every rising edge where both are high;
// in_ready never depends on in_valid. mem_we is held with mem_addr/mem_wdata until an edge with mem_ack=1.
interface instr_encoder_loader_if #(
  parameter int ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [2:0]        op_code;
  logic [4:0]        addr;
  logic [7:0]        x;
  logic [7:0]        y;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [23:0]       mem_wdata;
  logic              mem_ack;

  modport master (
    output in_valid, op_code, addr, x, y, mem_ack,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_valid, op_code, addr, x, y, mem_ack,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/instr_encoder_loader.sv
// Packs op/addr/x/y field sets into 24-bit words, buffers them in a small FIFO and
// writes them to consecutive instruction-memory addresses until the memory is full.
module instr_encoder_loader #(
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_W     = 8
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  instr_encoder_loader_if.slave          bus,
  output logic [ADDR_W:0]                prog_len,
  output logic                           mem_full,
  output logic [1:0]                     state_dbg,
  output logic [$clog2(FIFO_DEPTH):0]    fifo_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] wr_ptr;

  logic [23:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  head;
  logic [PTR_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic [23:0]       packed_word;
  logic              push;
  logic              pop;
  logic              last_ack;

  assign packed_word  = {bus.op_code, bus.addr, bus.x, bus.y};
  assign bus.in_ready = (count < CNT_W'(FIFO_DEPTH)) && (state != FULL) && !clr;
  assign push         = bus.in_valid && bus.in_ready;
  assign pop          = (state == IDLE) && (count != '0);
  // Acknowledge of the write to the top address: memory becomes full on this edge.
  assign last_ack     = (state == WRITE) && bus.mem_ack && (wr_ptr == '1);

  assign state_dbg  = state;
  assign fifo_count = count;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[tail] <= packed_word;
    end
  end

  // Buffer pointers; a clear or entry into FULL discards everything still queued.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (clr || last_ack) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      wr_ptr        <= '0;
      prog_len      <= '0;
      mem_full      <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else if (clr) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      prog_len   <= '0;
      mem_full   <= 1'b0;
      bus.mem_we <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (count != '0) begin
            bus.mem_wdata <= fifo_mem[head];
            bus.mem_addr  <= wr_ptr;
            bus.mem_we    <= 1'b1;
            state         <= WRITE;
          end
        end
        WRITE: begin
          if (bus.mem_ack) begin
            bus.mem_we <= 1'b0;
            prog_len   <= prog_len + 1'b1;
            // The pointer stays on the top address instead of wrapping.
            if (wr_ptr == '1) begin
              mem_full <= 1'b1;
              state    <= FULL;
            end else begin
              wr_ptr <= wr_ptr + 1'b1;
              state  <= IDLE;
            end
          end
        end
        FULL: begin
          bus.mem_we <= 1'b0;
          mem_full   <= 1'b1;
        end
        default: begin
          bus.mem_we <= 1'b0;
          state      <= IDLE;
        end
      endcase
    end
  end

endmodule
